// File: rtl/jit_pipeline_elastic_if.sv
// Handshake bundle for the elastic ALU pipeline.
// Producer drives a/b/mode/in_valid; consumer drives out_ready.
interface jit_pipeline_elastic_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 3,
  parameter int LO_W  = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic             tag;
  logic [WIDTH-1:0] data;
  logic [LO_W-1:0]  lo;
  logic [CNT_W-1:0] occupancy;

  modport master (
    output in_valid, a, b, mode, out_ready,
    input  in_ready, out_valid, tag, data, lo, occupancy
  );

  modport slave (
    input  in_valid, a, b, mode, out_ready,
    output in_ready, out_valid, tag, data, lo, occupancy
  );
endinterface

// File: rtl/jit_pipeline_elastic.sv
// Back-pressurable DEPTH-stage ALU pipeline with bubble collapsing,
// synchronous flush and registered occupancy count.
module jit_pipeline_elastic #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 3,
  parameter int LO_W  = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input logic sys_clk,
  input logic sys_rst_n,
  input logic flush,
  jit_pipeline_elastic_if.slave bus
);

  typedef struct packed {
    logic             tag;
    logic [WIDTH-1:0] data;
    logic [LO_W-1:0]  lo;
  } pay_t;

  pay_t             p [DEPTH];
  pay_t             pc [DEPTH];
  pay_t             p_in;
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] v_nxt;
  logic [DEPTH-1:0] vc;
  logic [DEPTH-1:0] ld;
  logic [CNT_W-1:0] occ;
  logic [CNT_W-1:0] occ_nxt;
  logic [WIDTH-1:0] alu;
  logic             acc;

  always_comb begin
    alu = '0;
    unique case (bus.mode)
      2'b00: alu = bus.a + bus.b;
      2'b01: alu = bus.a ^ bus.b;
      2'b10: alu = bus.a - bus.b;
      2'b11: alu = bus.a & bus.b;
    endcase
  end

  always_comb begin
    p_in.tag  = (bus.a == bus.b);
    p_in.data = alu;
    p_in.lo   = alu[LO_W-1:0];
  end

  // A stage may load when any stage at or above it has a hole,
  // or the consumer drains the last stage.
  always_comb begin
    logic gap;
    gap = bus.out_ready;
    ld  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      gap   = gap | !v[i];
      ld[i] = gap;
    end
  end

  assign bus.in_ready = ld[0] & !flush & sys_rst_n;
  assign acc          = bus.in_valid & bus.in_ready;

  always_comb begin
    vc    = '0;
    vc[0] = acc;
    pc[0] = p_in;
    for (int i = 1; i < DEPTH; i++) begin
      vc[i] = v[i-1];
      pc[i] = p[i-1];
    end
  end

  always_comb begin
    v_nxt   = v;
    occ_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ld[i]) v_nxt[i] = vc[i];
    end
    if (flush) v_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_nxt = occ_nxt + CNT_W'(v_nxt[i]);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      v   <= '0;
      occ <= '0;
      for (int i = 0; i < DEPTH; i++) p[i] <= '0;
    end else begin
      v   <= v_nxt;
      occ <= occ_nxt;
      for (int i = 0; i < DEPTH; i++) begin
        if (ld[i] && vc[i]) p[i] <= pc[i];
      end
    end
  end

  assign bus.out_valid = v[DEPTH-1];
  assign bus.tag       = p[DEPTH-1].tag;
  assign bus.data      = p[DEPTH-1].data;
  assign bus.lo        = p[DEPTH-1].lo;
  assign bus.occupancy = occ;

endmodule

// File: tb/tb_jit_pipeline_elastic.sv
// Self-checking bench for jit_pipeline_elastic: directed scenarios
// plus randomized traffic against an in-order queue model.
module tb_jit_pipeline_elastic;
  localparam int W  = 16;
  localparam int D  = 3;
  localparam int L  = 8;
  localparam int PW = W + L + 1;

  logic sys_clk;
  logic sys_rst_n;
  logic flush;
  int   checks = 0;
  int   passes = 0;
  logic [PW-1:0] q[$];

  jit_pipeline_elastic_if #(.WIDTH(W), .DEPTH(D), .LO_W(L)) bus ();

  jit_pipeline_elastic #(.WIDTH(W), .DEPTH(D), .LO_W(L)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .flush    (flush),
    .bus      (bus.slave)
  );

  initial begin
    sys_clk = 0;
    forever #5 sys_clk = ~sys_clk;
  end

  function automatic logic [PW-1:0] model(
    input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] m);
    logic [W-1:0] r;
    logic [L-1:0] l;
    case (m)
      2'd0:    r = x + y;
      2'd1:    r = x ^ y;
      2'd2:    r = x - y;
      default: r = x & y;
    endcase
    l = r[L-1:0];
    return {x == y, r, l};
  endfunction

  // Scoreboard: in-flight items form an ordered queue.
  always @(negedge sys_clk) begin
    logic    er;
    logic [PW-1:0] e;
    if (!sys_rst_n) begin
      q.delete();
    end else begin
      er = !flush && (q.size() < D || bus.out_ready);
      checks++;
      if (bus.in_ready !== er)
        $display("FAIL sb_in_ready got=%b exp=%b t=%0t", bus.in_ready, er, $time);
      else passes++;
      checks++;
      if (bus.occupancy !== q.size())
        $display("FAIL sb_occupancy got=%0d exp=%0d t=%0t",
                 bus.occupancy, q.size(), $time);
      else passes++;
      if (bus.out_valid && bus.out_ready && !flush) begin
        checks++;
        if (q.size() == 0) begin
          $display("FAIL sb_unexpected_out got=%h exp=none t=%0t",
                   {bus.tag, bus.data, bus.lo}, $time);
        end else begin
          e = q.pop_front();
          if ({bus.tag, bus.data, bus.lo} !== e)
            $display("FAIL sb_payload got=%h exp=%h t=%0t",
                     {bus.tag, bus.data, bus.lo}, e, $time);
          else passes++;
        end
      end
      if (flush) q.delete();
      else if (bus.in_valid && bus.in_ready)
        q.push_back(model(bus.a, bus.b, bus.mode));
    end
  end

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({bus.out_valid, bus.tag, bus.data, bus.lo, bus.occupancy} !== '0)
      $display("FAIL rst_outputs got=%b/%h/%0d exp=0",
               bus.out_valid, bus.data, bus.occupancy);
    else passes++;
    checks++;
    if (bus.in_ready !== 1'b0)
      $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready);
    else passes++;
    @(negedge sys_clk);
    #2 sys_rst_n = 1;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.occupancy !== 0 || bus.out_valid !== 0)
      $display("FAIL rst_release got=%b/%0d/%b exp=1/0/0",
               bus.in_ready, bus.occupancy, bus.out_valid);
    else passes++;
  endtask

  task automatic send_timed(input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic [1:0] m, input logic [W-1:0] ed,
                            input logic et, input logic [L-1:0] el,
                            input string nm);
    int k;
    bus.a = x; bus.b = y; bus.mode = m;
    bus.in_valid = 1; bus.out_ready = 1;
    @(negedge sys_clk);
    checks++;
    if (bus.in_ready !== 1'b1)
      $display("FAIL %s_accept got=%b exp=1", nm, bus.in_ready);
    else passes++;
    tick();
    bus.in_valid = 0;
    k = 0;
    do begin
      @(negedge sys_clk);
      k++;
    end while (!bus.out_valid && k < 10);
    checks++;
    if (k != D)
      $display("FAIL %s_latency got=%0d exp=%0d", nm, k, D);
    else passes++;
    checks++;
    if ({bus.tag, bus.data, bus.lo} !== {et, ed, el})
      $display("FAIL %s_result got=%b/%h/%h exp=%b/%h/%h",
               nm, bus.tag, bus.data, bus.lo, et, ed, el);
    else passes++;
    tick();
  endtask

  task automatic test_alu;
    send_timed(16'h1234, 16'h0F0F, 2'b00, 16'h2143, 1'b0, 8'h43, "add");
    send_timed(16'h00FF, 16'h00FF, 2'b01, 16'h0000, 1'b1, 8'h00, "xor");
    send_timed(16'h0000, 16'h0001, 2'b10, 16'hFFFF, 1'b0, 8'hFF, "sub_wrap");
    send_timed(16'hFFFF, 16'h0001, 2'b00, 16'h0000, 1'b0, 8'h00, "add_wrap");
    send_timed(16'hF0F0, 16'h3C3C, 2'b11, 16'h3030, 1'b0, 8'h30, "and");
  endtask

  task automatic test_backpressure;
    int nxt_in, nxt_out, gaps;
    bit started, took;
    bus.out_ready = 0; bus.mode = 0; bus.b = 0;
    for (int i = 1; i <= 3; i++) begin
      bus.a = W'(i); bus.in_valid = 1;
      @(negedge sys_clk);
      checks++;
      if (bus.in_ready !== 1'b1)
        $display("FAIL bp_fill%0d got=%b exp=1", i, bus.in_ready);
      else passes++;
      tick();
    end
    bus.a = 4;
    @(negedge sys_clk);
    checks++;
    if (bus.occupancy !== 2'd3 || bus.in_ready !== 1'b0)
      $display("FAIL bp_full got=%0d/%b exp=3/0", bus.occupancy, bus.in_ready);
    else passes++;
    tick();
    bus.out_ready = 1;
    nxt_in = 4; nxt_out = 1; gaps = 0; started = 0;
    for (int c = 0; c < 30 && nxt_out <= 8; c++) begin
      @(negedge sys_clk);
      if (bus.in_valid) begin
        checks++;
        if (bus.occupancy !== 2'd3)
          $display("FAIL bp_stream_occ got=%0d exp=3", bus.occupancy);
        else passes++;
      end
      if (bus.out_valid) begin
        checks++;
        if (bus.data !== W'(nxt_out))
          $display("FAIL bp_order got=%h exp=%h", bus.data, W'(nxt_out));
        else passes++;
        nxt_out++;
        started = 1;
      end else if (started) gaps++;
      took = bus.in_valid && bus.in_ready;
      tick();
      if (took) begin
        if (nxt_in == 8) bus.in_valid = 0;
        else begin nxt_in++; bus.a = W'(nxt_in); end
      end
    end
    checks++;
    if (nxt_out != 9 || gaps != 0)
      $display("FAIL bp_stream got=%0d items/%0d gaps exp=8/0", nxt_out - 1, gaps);
    else passes++;
  endtask

  task automatic test_bubble;
    bus.out_ready = 0;
    bus.a = 16'h0101; bus.b = 16'h0202; bus.mode = 2'b01;
    bus.in_valid = 1;
    tick();
    bus.in_valid = 0;
    @(negedge sys_clk);
    checks++;
    if (bus.occupancy !== 2'd1 || bus.out_valid !== 1'b0)
      $display("FAIL bub_edge1 got=%0d/%b exp=1/0", bus.occupancy, bus.out_valid);
    else passes++;
    tick();
    @(negedge sys_clk);
    checks++;
    if (bus.out_valid !== 1'b0)
      $display("FAIL bub_edge2 got=%b exp=0", bus.out_valid);
    else passes++;
    tick();
    @(negedge sys_clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.data !== 16'h0303)
      $display("FAIL bub_arrive got=%b/%h exp=1/0303", bus.out_valid, bus.data);
    else passes++;
    tick();
    for (int j = 0; j < 2; j++) begin
      bus.a = W'(j + 5); bus.in_valid = 1;
      @(negedge sys_clk);
      checks++;
      if (bus.in_ready !== 1'b1)
        $display("FAIL bub_fill%0d got=%b exp=1", j, bus.in_ready);
      else passes++;
      tick();
    end
    bus.a = 9;
    @(negedge sys_clk);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.occupancy !== 2'd3)
      $display("FAIL bub_refuse got=%b/%0d exp=0/3", bus.in_ready, bus.occupancy);
    else passes++;
    tick();
    bus.in_valid = 0; bus.out_ready = 1;
    repeat (5) tick();
    @(negedge sys_clk);
    checks++;
    if (bus.occupancy !== 0)
      $display("FAIL bub_drain got=%0d exp=0", bus.occupancy);
    else passes++;
    tick();
  endtask

  task automatic test_flush;
    bus.out_ready = 0; bus.mode = 0; bus.b = 16'h0010;
    bus.a = 16'h0001; bus.in_valid = 1;
    tick();
    bus.a = 16'h0002;
    tick();
    flush = 1; bus.a = 16'hDEAD;
    @(negedge sys_clk);
    checks++;
    if (bus.occupancy !== 2'd2 || bus.in_ready !== 1'b0)
      $display("FAIL fl_pre got=%0d/%b exp=2/0", bus.occupancy, bus.in_ready);
    else passes++;
    tick();
    flush = 0; bus.in_valid = 0;
    @(negedge sys_clk);
    checks++;
    if (bus.occupancy !== 0 || bus.out_valid !== 1'b0)
      $display("FAIL fl_post got=%0d/%b exp=0/0", bus.occupancy, bus.out_valid);
    else passes++;
    tick();
    send_timed(16'h0003, 16'h0004, 2'b00, 16'h0007, 1'b0, 8'h07, "fl_next");
  endtask

  task automatic test_reset_mid;
    int seen;
    bus.out_ready = 0; bus.mode = 0; bus.b = 0;
    for (int i = 1; i <= 3; i++) begin
      bus.a = W'(16'h1100 + i); bus.in_valid = 1;
      tick();
    end
    bus.in_valid = 0;
    @(negedge sys_clk);
    #2 sys_rst_n = 0;
    #1;
    checks++;
    if ({bus.out_valid, bus.tag, bus.data, bus.lo, bus.occupancy} !== '0)
      $display("FAIL rmid_outputs got=%b/%h/%0d exp=0",
               bus.out_valid, bus.data, bus.occupancy);
    else passes++;
    checks++;
    if (bus.in_ready !== 1'b0)
      $display("FAIL rmid_in_ready got=%b exp=0", bus.in_ready);
    else passes++;
    @(negedge sys_clk);
    #2 sys_rst_n = 1;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1)
      $display("FAIL rmid_release got=%b exp=1", bus.in_ready);
    else passes++;
    bus.out_ready = 1;
    seen = 0;
    repeat (6) begin
      @(negedge sys_clk);
      if (bus.out_valid) seen++;
      tick();
    end
    checks++;
    if (seen != 0)
      $display("FAIL rmid_stale got=%0d exp=0", seen);
    else passes++;
  endtask

  task automatic test_random;
    for (int c = 0; c < 600; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      flush         = ($urandom_range(0, 39) == 0);
      bus.a         = W'($urandom);
      bus.b         = ($urandom_range(0, 4) == 0) ? bus.a : W'($urandom);
      bus.mode      = 2'($urandom_range(0, 3));
      tick();
    end
    flush = 0; bus.in_valid = 0; bus.out_ready = 1;
    repeat (6) tick();
    @(negedge sys_clk);
    checks++;
    if (q.size() != 0 || bus.occupancy !== 0)
      $display("FAIL rnd_drain got=%0d/%0d exp=0/0", q.size(), bus.occupancy);
    else passes++;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    sys_rst_n = 0; flush = 0;
    bus.in_valid = 0; bus.out_ready = 0;
    bus.a = '0; bus.b = '0; bus.mode = '0;
    test_reset();
    test_alu();
    test_backpressure();
    test_bubble();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
